// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier supporting MUL/MULH/MULHSU/MULHU (N+2 edge latency,
// counting the accepting edge). Define SEQ_MUL_ZERO_BYPASS_EN to enable the 1-edge zero-operand fast path.

module ripple_carry_adder #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         CarryIn,
  output logic [W-1:0] Sum,
  output logic         CarryOut
);

  always_comb begin
    logic c;
    c   = CarryIn;
    Sum = '0;
    for (int unsigned i = 0; i < W; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    CarryOut = c;
  end

endmodule

module seq_multiplier #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         kill,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Result
);

  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic           a_neg_q, a_neg_d;
  logic           b_neg_q, b_neg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   result_q, result_d;
  logic           done_q, done_d;

  logic           a_signed, b_signed;
  logic           a_neg, b_neg;
  logic [N-1:0]   a_abs, b_abs;
  logic           zero_op;
  logic [N-1:0]   add_sum;
  logic           add_co;
  logic           step_c;
  logic [N-1:0]   step_h;
  logic           prod_neg;
  logic [2*N-1:0] prod_fix;

  assign a_signed = (op == 2'b01) || (op == 2'b10);
  assign b_signed = (op == 2'b01);
  assign a_neg    = a_signed & A[N-1];
  assign b_neg    = b_signed & B[N-1];
  assign a_abs    = a_neg ? -A : A;
  assign b_abs    = b_neg ? -B : B;

`ifdef SEQ_MUL_ZERO_BYPASS_EN
  assign zero_op = (A == '0) || (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  ripple_carry_adder #(.W(N)) u_add (
    .A        (acc_q[2*N-1:N]),
    .B        (mcand_q),
    .CarryIn  (1'b0),
    .Sum      (add_sum),
    .CarryOut (add_co)
  );

  // Carry-out of the add becomes the MSB after the right shift.
  assign {step_c, step_h} = mplier_q[0] ? {add_co, add_sum} : {1'b0, acc_q[2*N-1:N]};

  assign prod_neg = a_neg_q ^ b_neg_q;
  assign prod_fix = prod_neg ? -acc_q : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && !zero_op) state_d = CALC;
        CALC:    if (cnt_q == CW'(1)) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
  end

  always_comb begin
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (!kill) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (zero_op) begin
              result_d = '0;
              done_d   = 1'b1;
            end else begin
              op_d     = op;
              mcand_d  = a_abs;
              mplier_d = b_abs;
              a_neg_d  = a_neg;
              b_neg_d  = b_neg;
              acc_d    = '0;
              cnt_d    = CW'(N);
            end
          end
        end
        CALC: begin
          acc_d    = {step_c, step_h, acc_q[N-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
        end
        FIX: begin
          acc_d    = prod_fix;
          result_d = (op_q == 2'b00) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
          done_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have one parameter, N, default 32, giving the operand width; only N=32 is required to be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a multiply; sampled on a rising edge only while busy is low.
REQ-005 op  input  2  operation: 00 MUL (low word), 01 MULH (signed x signed, high word), 10 MULHSU (signed A x unsigned B, high word), 11 MULHU (unsigned x unsigned, high word).
REQ-006 A  input  N  multiplicand (rs1 value).
REQ-007 B  input  N  multiplier (rs2 value).
REQ-008 kill  input  1  pipeline flush; aborts any operation in progress.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  registered single-cycle pulse; Result is valid while it is high.
REQ-011 Result  output  N  selected product word.

Function
REQ-012 States SHALL be IDLE, CALC, FIX; busy SHALL be high exactly in CALC and FIX.
REQ-013 In IDLE, start=1 on an edge SHALL capture op, |A| and |B|, the product sign and the sign flags, clear the 2N-bit accumulator, load a 6-bit iteration counter with N, and enter CALC.
REQ-014 Operands SHALL be treated as signed only where op requires it: A is signed for 01 and 10; B is signed for 01 only.
REQ-015 Each CALC edge SHALL perform one radix-2 shift-add step: add |A| to the accumulator high half when the current multiplier LSB is 1, then shift the {carry, accumulator} right by 1 with the adder carry-out entering the MSB.
REQ-016 The N-bit add in each step SHALL be done by an instance of the team's ripple-carry adder with CarryIn=0; its CarryOut SHALL feed the shift.
REQ-017 After N CALC edges the state SHALL move to FIX; the FIX edge SHALL negate the 2N-bit product (two's complement) when the captured sign is negative.
REQ-018 On the FIX edge the state SHALL return to IDLE, Result SHALL load the low N bits for op=00 and the high N bits otherwise, and done SHALL go high for one cycle.
REQ-019 Latency SHALL be N+2 rising edges from the edge accepting start to the edge raising done (34 for N=32).
REQ-020 start while busy=1 SHALL be ignored with no effect on state or outputs.
REQ-021 start while done=1 (back-to-back) SHALL be accepted, since busy is low.
REQ-022 Result SHALL hold its value until the next done pulse; it SHALL NOT change during a later operation.
REQ-023 kill=1 on an edge SHALL force IDLE, clear busy, and suppress done; Result SHALL keep its previous value. kill has priority over start on the same edge.
REQ-024 The product SHALL be exact for all inputs, including MULH with A=B=0x80000000.

Reset
REQ-025 While rst_n=0, the block SHALL immediately force state IDLE, busy=0, done=0, Result=0, counter=0, and accumulator=0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard the operation; no done SHALL follow reset release.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n rises.

Configuration
REQ-028 Macro SEQ_MUL_ZERO_BYPASS_EN, when defined, SHALL add a fast path: if A=0 or B=0 at the accepting edge, the block SHALL go directly from IDLE to IDLE with Result=0 and done pulsed one edge later (latency 1), and busy SHALL stay low.
REQ-029 Without SEQ_MUL_ZERO_BYPASS_EN, zero operands SHALL take the normal N+2 latency and produce Result=0.

Verification
REQ-030 MUL with A=7, B=6 -> done 34 edges after start, Result=0x0000002A.
REQ-031 A=B=0xFFFFFFFF: MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001.
REQ-032 MULHSU with A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF; MULH with A=B=0x80000000 -> 0x40000000.
REQ-033 kill on the 10th CALC edge -> busy low next cycle, no done, old Result held; next start completes normally in 34 edges.
REQ-034 start pulsed while busy with different operands -> ignored, first result correct; rst_n low at CALC edge 5 -> all outputs 0 at once, no done afterwards.
REQ-035 MUL with A=0, B=5 -> Result=0 with latency 1 when SEQ_MUL_ZERO_BYPASS_EN is defined, latency 34 when it is not.
